// File: rtl/io_sequencer_pkg.sv
// io_sequencer_pkg: shared state encodings, requester IDs and phase-counter type for the I/O sequencer
package io_sequencer_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
    // A phase lasting cyc cycles counts down from cyc-1 to 0.
    function automatic cnt_t cyc_load(int cyc);
        return cnt_t'(cyc - 1);
    endfunction
endpackage

// File: rtl/io_sequencer_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter for the I/O sequencer
//   clk_i, rst_i   clock, async active-high reset
//   req_i[1:0]     requests indexed by requester ID (REQ_CPU / REQ_DMA)
//   enable_i       arbitration allowed this cycle
//   gnt_valid_o    a grant is issued this cycle
//   gnt_id_o       ID of the granted requester
module rr_arb2
    import io_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);
    logic last_q;
    assign gnt_valid_o = enable_i && (|req_i);
    // On a tie the requester that did not win last time goes next.
    assign gnt_id_o = (&req_i) ? ~last_q : req_i[REQ_DMA];
    // Reset to DMA so the CPU wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= REQ_DMA;
        else if (gnt_valid_o) last_q <= gnt_id_o;
    end
endmodule

// File: rtl/io_sequencer.sv
// io_sequencer: shares the 16-bit peripheral data port between CPU PIO and DMA with SETUP/STROBE/HOLD timing
//   clk_i, rst_i                         clock, async active-high reset
//   cpu_req_i/cpu_rw_i/cpu_wdata_i       CPU request (rw 1 = read), held until cpu_ack_o
//   dma_req_i/dma_rw_i/dma_wdata_i       DMA request (rw 1 = read), held until dma_ack_o
//   cpu_ack_o, dma_ack_o                 1-cycle completion pulses
//   rdata_o                              last captured read data
//   port_ena_n_o, port_r_w_o, port_wdata_o, port_rdata_i, cs_n_o   peripheral port side
//   busy_o                               high outside IDLE
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_rw_i,
    input  logic [15:0] cpu_wdata_i,
    output logic        cpu_ack_o,
    input  logic        dma_req_i,
    input  logic        dma_rw_i,
    input  logic [15:0] dma_wdata_i,
    output logic        dma_ack_o,
    output logic [15:0] rdata_o,
    output logic        port_ena_n_o,
    output logic        port_r_w_o,
    output logic [15:0] port_wdata_o,
    input  logic [15:0] port_rdata_i,
    output logic        cs_n_o,
    output logic        busy_o
);
    localparam cnt_t SETUP_LD  = cyc_load(SETUP_CYC);
    localparam cnt_t STROBE_LD = cyc_load(STROBE_CYC);
    localparam cnt_t HOLD_LD   = cyc_load(HOLD_CYC);
    logic [1:0]  state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        rw_q, id_q, cpu_ack_q, dma_ack_q;
    logic [15:0] wdata_q, rdata_q;
    logic [1:0]  req;
    logic        gnt_valid, gnt_id, done, idle, grant, capture, finish;
    // A requester still holding REQ during its ACK cycle must not be re-granted.
    assign req     = {dma_req_i && !dma_ack_q, cpu_req_i && !cpu_ack_q};
    assign idle    = state_q == ST_IDLE;
    assign done    = cnt_q == '0;
    assign grant   = idle && gnt_valid;
    assign capture = state_q == ST_STROBE && done && rw_q;
    assign finish  = state_q == ST_HOLD && done;
    rr_arb2 u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req),
        .enable_i   (idle),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = done ? cnt_q : cnt_q - cnt_t'(1);
        case (state_q)
            ST_IDLE:   if (gnt_valid) begin state_d = ST_SETUP;  cnt_d = SETUP_LD;  end
            ST_SETUP:  if (done)      begin state_d = ST_STROBE; cnt_d = STROBE_LD; end
            ST_STROBE: if (done)      begin state_d = ST_HOLD;   cnt_d = HOLD_LD;   end
            default:   if (done)      state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b1;
            id_q      <= REQ_CPU;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpu_ack_q <= finish && id_q == REQ_CPU;
            dma_ack_q <= finish && id_q == REQ_DMA;
            if (grant) begin
                id_q    <= gnt_id;
                rw_q    <= gnt_id ? dma_rw_i : cpu_rw_i;
                wdata_q <= gnt_id ? dma_wdata_i : cpu_wdata_i;
            end
            if (capture) rdata_q <= port_rdata_i;
        end
    end
    // Port controls are decoded from registered state only, so reset forces them idle at once
    // and ENA_n can only go low while R_W is low.
    assign port_r_w_o   = idle || rw_q;
    assign port_ena_n_o = idle || rw_q;
    assign cs_n_o       = state_q != ST_STROBE;
    assign port_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign dma_ack_o    = dma_ack_q;
    assign busy_o       = !idle;
endmodule

// File: tb/tb_io_sequencer.sv
// tb_io_sequencer: directed self-checking bench for io_sequencer (default timing plus a 1/1/1 instance)
module tb_io_sequencer;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_rw = 1'b0, dma_req = 1'b0, dma_rw = 1'b0;
    logic [15:0] cpu_wdata = '0, dma_wdata = '0, port_rdata = '0;
    logic        cpu_ack, dma_ack, ena_n, r_w, cs_n, busy;
    logic [15:0] rdata, port_wdata;
    logic        f_cpu_req = 1'b0, f_cpu_rw = 1'b0, f_dma_req = 1'b0, f_dma_rw = 1'b0;
    logic [15:0] f_cpu_wdata = '0, f_dma_wdata = '0, f_port_rdata = '0;
    logic        f_cpu_ack, f_dma_ack, f_ena_n, f_r_w, f_cs_n, f_busy;
    logic [15:0] f_rdata, f_port_wdata;
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    io_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_rw_i(cpu_rw), .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack),
        .dma_req_i(dma_req), .dma_rw_i(dma_rw), .dma_wdata_i(dma_wdata), .dma_ack_o(dma_ack),
        .rdata_o(rdata), .port_ena_n_o(ena_n), .port_r_w_o(r_w), .port_wdata_o(port_wdata),
        .port_rdata_i(port_rdata), .cs_n_o(cs_n), .busy_o(busy)
    );

    io_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(f_cpu_req), .cpu_rw_i(f_cpu_rw), .cpu_wdata_i(f_cpu_wdata), .cpu_ack_o(f_cpu_ack),
        .dma_req_i(f_dma_req), .dma_rw_i(f_dma_rw), .dma_wdata_i(f_dma_wdata), .dma_ack_o(f_dma_ack),
        .rdata_o(f_rdata), .port_ena_n_o(f_ena_n), .port_r_w_o(f_r_w), .port_wdata_o(f_port_wdata),
        .port_rdata_i(f_port_rdata), .cs_n_o(f_cs_n), .busy_o(f_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        tests++;
        if ({cs_n, ena_n, r_w, port_wdata, rdata, cpu_ack, dma_ack, busy} !== {3'b111, 16'h0, 16'h0, 3'b000}) begin
            failed++;
            $display("FAIL reset: cs_n/ena_n/r_w=%b%b%b wdata=%h rdata=%h acks=%b%b busy=%b, want 111 0000 0000 00 0",
                     cs_n, ena_n, r_w, port_wdata, rdata, cpu_ack, dma_ack, busy);
        end
        tests++;
        if ({f_cs_n, f_busy, f_rdata} !== {2'b10, 16'h0}) begin
            failed++;
            $display("FAIL reset_fast: cs_n=%b busy=%b rdata=%h, want 1 0 0000", f_cs_n, f_busy, f_rdata);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_cpu_write;
        logic [5:0] exp;
        cpu_rw = 1'b0;
        cpu_wdata = 16'hA55A;
        cpu_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp = {!(i >= 3 && i <= 5), i == 7, i == 7, i == 7, 1'b0, i <= 6};
            tests++;
            if ({cs_n, ena_n, r_w, cpu_ack, dma_ack, busy} !== exp) begin
                failed++;
                $display("FAIL cpu_write cyc%0d: cs_n,ena_n,r_w,cpu_ack,dma_ack,busy=%b want %b",
                         i, {cs_n, ena_n, r_w, cpu_ack, dma_ack, busy}, exp);
            end
            if (i <= 6) begin
                tests++;
                if (port_wdata !== 16'hA55A) begin
                    failed++;
                    $display("FAIL cpu_write_data cyc%0d: port_wdata=%h want a55a", i, port_wdata);
                end
            end
            // Changes after the grant edge must not reach the port.
            if (i == 1) begin cpu_wdata = 16'hFFFF; cpu_rw = 1'b1; end
            if (i == 7) cpu_req = 1'b0;
        end
        step();
        tests++;
        if ({busy, cpu_ack} !== 2'b00) begin
            failed++;
            $display("FAIL cpu_write_after: busy,cpu_ack=%b want 00", {busy, cpu_ack});
        end
        cpu_rw = 1'b0;
    endtask

    task automatic test_dma_read;
        logic [5:0] exp;
        dma_rw = 1'b1;
        dma_wdata = 16'h7777;
        port_rdata = 16'h0000;
        dma_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp = {!(i >= 3 && i <= 5), 1'b1, 1'b1, i == 7, 1'b0, i <= 6};
            tests++;
            if ({cs_n, ena_n, r_w, dma_ack, cpu_ack, busy} !== exp) begin
                failed++;
                $display("FAIL dma_read cyc%0d: cs_n,ena_n,r_w,dma_ack,cpu_ack,busy=%b want %b",
                         i, {cs_n, ena_n, r_w, dma_ack, cpu_ack, busy}, exp);
            end
            if (i == 2) port_rdata = 16'h1234;
            if (i == 6) port_rdata = 16'hBEEF;
            if (i == 7) begin
                tests++;
                if (rdata !== 16'h1234) begin
                    failed++;
                    $display("FAIL dma_read_data: rdata=%h want 1234", rdata);
                end
                dma_req = 1'b0;
            end
        end
        step();
        tests++;
        if ({busy, rdata} !== {1'b0, 16'h1234}) begin
            failed++;
            $display("FAIL dma_read_hold: busy=%b rdata=%h want 0 1234", busy, rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        cpu_rw = 1'b0;
        cpu_wdata = 16'h1111;
        dma_rw = 1'b0;
        dma_wdata = 16'h2222;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            step();
            exp = {c == 7 || c == 21, c == 14 || c == 28, !(c % 7 == 0) && c != 29};
            tests++;
            if ({cpu_ack, dma_ack, busy} !== exp) begin
                failed++;
                $display("FAIL back_to_back cyc%0d: cpu_ack,dma_ack,busy=%b want %b",
                         c, {cpu_ack, dma_ack, busy}, exp);
            end
            if (c == 1 || c == 8) begin
                tests++;
                if (port_wdata !== (c == 1 ? 16'h1111 : 16'h2222)) begin
                    failed++;
                    $display("FAIL back_to_back_data cyc%0d: port_wdata=%h", c, port_wdata);
                end
            end
            if (c == 26) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
    endtask

    task automatic test_reset_abort;
        cpu_rw = 1'b0;
        cpu_wdata = 16'h0F0F;
        cpu_req = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        tests++;
        if ({cs_n, ena_n} !== 2'b00) begin
            failed++;
            $display("FAIL abort_pre: cs_n,ena_n=%b want 00", {cs_n, ena_n});
        end
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        tests++;
        if ({cs_n, ena_n, r_w, busy} !== 4'b1110) begin
            failed++;
            $display("FAIL abort_async: cs_n,ena_n,r_w,busy=%b want 1110", {cs_n, ena_n, r_w, busy});
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            tests++;
            if ({cpu_ack, dma_ack, busy} !== 3'b000) begin
                failed++;
                $display("FAIL abort_no_ack cyc%0d: cpu_ack,dma_ack,busy=%b want 000", i, {cpu_ack, dma_ack, busy});
            end
        end
        cpu_wdata = 16'h1357;
        cpu_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            tests++;
            if ({cpu_ack, busy} !== {i == 7, i <= 6}) begin
                failed++;
                $display("FAIL abort_retry cyc%0d: cpu_ack,busy=%b want %b", i, {cpu_ack, busy}, {i == 7, i <= 6});
            end
            if (i == 1) begin
                tests++;
                if (port_wdata !== 16'h1357) begin
                    failed++;
                    $display("FAIL abort_retry_data: port_wdata=%h want 1357", port_wdata);
                end
            end
            if (i == 7) cpu_req = 1'b0;
        end
    endtask

    task automatic test_fast_read;
        logic [2:0] exp;
        f_cpu_rw = 1'b1;
        f_port_rdata = 16'hC3C3;
        f_cpu_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp = {i != 2, i == 4, i <= 3};
            tests++;
            if ({f_cs_n, f_cpu_ack, f_busy} !== exp) begin
                failed++;
                $display("FAIL fast_read cyc%0d: cs_n,cpu_ack,busy=%b want %b", i, {f_cs_n, f_cpu_ack, f_busy}, exp);
            end
            if (i == 3) f_port_rdata = 16'h0000;
            if (i == 4) begin
                tests++;
                if (f_rdata !== 16'hC3C3) begin
                    failed++;
                    $display("FAIL fast_read_data: rdata=%h want c3c3", f_rdata);
                end
                f_cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_req_drop;
        cpu_rw = 1'b0;
        cpu_wdata = 16'h2468;
        cpu_req = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 1) cpu_req = 1'b0;
            tests++;
            if ({cpu_ack, dma_ack, busy} !== {i == 7, 1'b0, i <= 6}) begin
                failed++;
                $display("FAIL req_drop cyc%0d: cpu_ack,dma_ack,busy=%b want %b",
                         i, {cpu_ack, dma_ack, busy}, {i == 7, 1'b0, i <= 6});
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_back_to_back();
        test_reset_abort();
        test_fast_read();
        test_req_drop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
